led_mix_columns_serial: RTL and testbench



---
 rtl/led_mix_columns_serial.sv | 91 +++++++++
 tb/tb_led_mix_columns_serial.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mix_columns_serial.sv
// LED MixColumnsSerial: applies the serial matrix A once per clock, STEPS times,
// to all four columns of a 64-bit state (STEPS=4 gives M = A^4).
module led_mix_columns_serial #(
  parameter int STEPS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] state_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] state_out,
  output logic [1:0]  state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE; out_valid is high only in DONE, with state_out
  // held stable until out_ready is seen. Both read 0 while rst is asserted.

  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      work_q;
  logic [63:0]      step_res;
  logic             last_step;

  // GF(2^4) doubling modulo x^4+x+1
  function automatic logic [3:0] dbl(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
  endfunction

  // Nibble i sits at [63-4i -: 4], so row 0 occupies the top 16 bits.
  always_comb begin
    step_res = '0;
    for (int c = 0; c < 4; c++) begin
      step_res[63-4*c -: 4]      = work_q[63-4*(4+c) -: 4];
      step_res[63-4*(4+c) -: 4]  = work_q[63-4*(8+c) -: 4];
      step_res[63-4*(8+c) -: 4]  = work_q[63-4*(12+c) -: 4];
      step_res[63-4*(12+c) -: 4] = dbl(dbl(work_q[63-4*c -: 4]))
                                 ^ work_q[63-4*(4+c) -: 4]
                                 ^ dbl(work_q[63-4*(8+c) -: 4])
                                 ^ dbl(work_q[63-4*(12+c) -: 4]);
    end
  end

  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      state_out <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q <= state_in;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          work_q <= step_res;
          cnt_q  <= cnt_q + 1'b1;
          if (last_step) state_out <= step_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_mix_columns_serial.sv
// Bench for led_mix_columns_serial: a STEPS=4 instance under random and directed
// traffic, plus a STEPS=1 instance, checked against a GF(2^4) matrix-power model.
module tb_led_mix_columns_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [63:0] state_in;
  logic        in_ready, out_valid;
  logic [63:0] state_out;
  logic [1:0]  dbg0;

  logic        in_valid1, out_ready1;
  logic [63:0] state_in1;
  logic        in_ready1, out_valid1;
  logic [63:0] state_out1;
  logic [1:0]  dbg1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_acc = -1;
  bit b2b = 1'b0;
  bit prev_ov = 1'b0;
  logic [63:0] exp_q[$];

  led_mix_columns_serial #(.STEPS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .state_dbg(dbg0)
  );

  led_mix_columns_serial #(.STEPS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .state_in(state_in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .state_out(state_out1), .state_dbg(dbg1)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // reference model: out = A^steps * in over GF(2^4), column by column
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p = 4'h0;
    logic [3:0] aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] s, input int steps);
    logic [3:0] a[16] = '{4'h0, 4'h1, 4'h0, 4'h0,
                          4'h0, 4'h0, 4'h1, 4'h0,
                          4'h0, 4'h0, 4'h0, 4'h1,
                          4'h4, 4'h1, 4'h2, 4'h2};
    logic [3:0] p[16];
    logic [3:0] t[16];
    logic [3:0] acc;
    logic [63:0] o = '0;
    for (int i = 0; i < 16; i++) p[i] = (i % 5 == 0) ? 4'h1 : 4'h0;
    for (int n = 0; n < steps; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          acc = 4'h0;
          for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(p[r*4+k], a[k*4+c]);
          t[r*4+c] = acc;
        end
      p = t;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        acc = 4'h0;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(p[r*4+k], s[63-4*(k*4+c) -: 4]);
        o[63-4*(r*4+c) -: 4] = acc;
      end
    return o;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // scoreboard monitor for the STEPS=4 instance
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(state_in, 4));
        if (b2b && last_acc >= 0) check_eq("issue_gap", 64'(cyc - last_acc), 64'd6);
        last_acc = cyc;
        acc_cyc  = cyc;
      end
      if (out_valid && !prev_ov) check_eq("latency", 64'(cyc - acc_cyc), 64'd5);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_out", 64'd1, 64'd0);
        else check_eq("result", state_out, exp_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  // driver tasks
  task automatic send(input logic [63:0] d);
    bit ok = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b1;
    state_in = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    if (!ok) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_out();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("out_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic op1(input logic [63:0] d, input logic [63:0] want, input string tag);
    bit ok = 1'b0;
    int acc = 0;
    @(posedge clk); #2;
    in_valid1 = 1'b1;
    state_in1 = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready1) begin ok = 1'b1; break; end
    end
    acc = cyc;
    @(posedge clk); #2;
    in_valid1 = 1'b0;
    if (!ok) check_eq("accept1_timeout", 64'd0, 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid1) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("out1_timeout", 64'd0, 64'd1);
    check_eq(tag, state_out1, want);
    check_eq("latency1", 64'(cyc - acc), 64'd2);
  endtask

  logic [63:0] d, hold;

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;  state_in  = rand64();  out_ready  = 1'b1;
    in_valid1 = 1'b1; state_in1 = rand64();  out_ready1 = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_state_out", state_out, 64'h0);
    @(posedge clk); #2;
    rst = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("post_rst_in_ready1", 64'(in_ready1), 64'd1);

    // directed vectors
    send(64'h1111_0000_0000_0000); wait_out();
    check_eq("row0_ones", state_out, 64'h4444_8888_BBBB_2222);
    wait_idle();
    send(64'h0000_0000_0000_1111); wait_out();
    check_eq("row3_ones", state_out, 64'h2222_6666_9999_BBBB);
    wait_idle();
    send(64'h0); wait_out();
    check_eq("all_zero", state_out, 64'h0);
    wait_idle();

    // STEPS=1 instance: single A step
    op1(64'h0000_0000_0000_1111, 64'h0000_0000_1111_2222, "steps1_row3");
    for (int i = 0; i < 3; i++) begin
      d = rand64();
      op1(d, model(d, 1), "steps1_rand");
    end

    // backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    send(rand64()); wait_out();
    hold = state_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      in_valid = i[0];
      state_in = rand64();
      @(negedge clk);
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_state_out", state_out, hold);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check_eq("release_in_ready", 64'(in_ready), 64'd1);
    check_eq("release_out_valid", 64'(out_valid), 64'd0);

    // back-to-back traffic with fresh random states every cycle
    @(posedge clk); #2;
    last_acc = -1; b2b = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      state_in = rand64();
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    wait_idle();
    b2b = 1'b0;

    // reset while RUN with cnt=2
    send(rand64());
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_state_out", state_out, 64'h0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_eq("after_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      d = rand64();
      send(d); wait_out();
      check_eq("after_rst_result", state_out, model(d, 4));
      wait_idle();
    end
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
